// File: rtl/regfile_access_ctrl_pkg.sv
// Shared definitions for the register-file access controller: command
// opcodes, FSM state encoding and default geometry of the register file.
package regfile_access_ctrl_pkg;

  localparam int SIZE_DEFAULT = 16;
  localparam int ADDR_DEFAULT = 4;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_COPY  = 2'b10,
    OP_FILL  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD    = 3'd1,
    ST_WR    = 3'd2,
    ST_FILL  = 3'd3,
    ST_CP_RD = 3'd4,
    ST_CP_WR = 3'd5,
    ST_RSP   = 3'd6
  } state_e;

  // True for the states that drive a write strobe into the register file.
  function automatic logic is_write_state(input state_e st);
    logic res;
    case (st)
      ST_WR, ST_FILL, ST_CP_WR: res = 1'b1;
      default:                  res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/regfile_addr_gen.sv
// Address generator for block operations: holds the current source and
// destination pointers plus the remaining-element counter. Pointers move up
// or down by one per step and wrap naturally modulo 2**addr. The counter is
// one bit wider than an address so a full-file length (len = 2**addr-1)
// loads as 2**addr and still terminates.
module regfile_addr_gen
  import regfile_access_ctrl_pkg::*;
#(
  parameter int addr = ADDR_DEFAULT
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            load,
  input  logic            step,
  input  logic            desc,
  input  logic [addr-1:0] src,
  input  logic [addr-1:0] dst,
  input  logic [addr-1:0] len,
  output logic [addr-1:0] cur_src,
  output logic [addr-1:0] cur_dst,
  output logic            last
);

  logic [addr-1:0] cur_src_r;
  logic [addr-1:0] cur_dst_r;
  logic [addr:0]   remaining_r;
  logic            desc_r;

  // Load start pointers (top end when descending) or advance one element.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_src_r   <= '0;
      cur_dst_r   <= '0;
      remaining_r <= '0;
      desc_r      <= 1'b0;
    end else if (load) begin
      desc_r      <= desc;
      remaining_r <= {1'b0, len} + {{addr{1'b0}}, 1'b1};
      if (desc) begin
        cur_src_r <= src + len;
        cur_dst_r <= dst + len;
      end else begin
        cur_src_r <= src;
        cur_dst_r <= dst;
      end
    end else if (step) begin
      remaining_r <= remaining_r - {{addr{1'b0}}, 1'b1};
      if (desc_r) begin
        cur_src_r <= cur_src_r - {{(addr-1){1'b0}}, 1'b1};
        cur_dst_r <= cur_dst_r - {{(addr-1){1'b0}}, 1'b1};
      end else begin
        cur_src_r <= cur_src_r + {{(addr-1){1'b0}}, 1'b1};
        cur_dst_r <= cur_dst_r + {{(addr-1){1'b0}}, 1'b1};
      end
    end else begin
      remaining_r <= remaining_r;
    end
  end

  assign cur_src = cur_src_r;
  assign cur_dst = cur_dst_r;
  assign last    = (remaining_r == {{addr{1'b0}}, 1'b1});

endmodule

// File: rtl/regfile_access_ctrl.sv
// Command-driven initiator for a register file with one write port and one
// combinational read port. Executes READ, WRITE, FILL and memmove-style COPY.
// Optional build macro RFC_DONE_RSP_EN: WRITE/FILL/COPY also return a
// completion response carrying the element count.
// All rf_* and handshake outputs are decoded from registered state only.
module regfile_access_ctrl
  import regfile_access_ctrl_pkg::*;
#(
  parameter int size = SIZE_DEFAULT,
  parameter int addr = ADDR_DEFAULT
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_op,
  input  logic [addr-1:0] cmd_src,
  input  logic [addr-1:0] cmd_dst,
  input  logic [addr-1:0] cmd_len,
  input  logic [size-1:0] cmd_data,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [size-1:0] rsp_data,
  output logic [addr-1:0] rf_write_addr,
  output logic            rf_write_en,
  output logic [size-1:0] rf_data_in,
  output logic [addr-1:0] rf_read_addr,
  input  logic [size-1:0] rf_data_out
);

`ifdef RFC_DONE_RSP_EN
  localparam state_e DONE_STATE = ST_RSP;
`else
  localparam state_e DONE_STATE = ST_IDLE;
`endif

  state_e          state_r;
  state_e          state_nx;
  logic [size-1:0] data_r;
  logic [size-1:0] buf_r;
  logic [size-1:0] rsp_data_r;
  logic            load_s;
  logic            step_s;
  logic            desc_s;
  logic [addr-1:0] diff_s;
  logic [addr-1:0] cur_src_s;
  logic [addr-1:0] cur_dst_s;
  logic            last_s;
`ifdef RFC_DONE_RSP_EN
  logic [addr-1:0] len_r;
  logic [addr:0]   count_s;
`endif

  // Copy runs top-down only when the destination starts inside the source
  // block ahead of it; every other case (including dst == src) runs upward.
  assign diff_s = cmd_dst - cmd_src;
  assign desc_s = (cmd_op == OP_COPY) && (diff_s != '0) && (diff_s <= cmd_len);

  regfile_addr_gen #(
    .addr (addr)
  ) u_addr_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load_s),
    .step    (step_s),
    .desc    (desc_s),
    .src     (cmd_src),
    .dst     (cmd_dst),
    .len     (cmd_len),
    .cur_src (cur_src_s),
    .cur_dst (cur_dst_s),
    .last    (last_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Next-state logic plus address-generator load/step strobes.
  always_comb begin
    state_nx = state_r;
    load_s   = 1'b0;
    step_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid) begin
          load_s = 1'b1;
          case (op_e'(cmd_op))
            OP_READ:  state_nx = ST_RD;
            OP_WRITE: state_nx = ST_WR;
            OP_COPY:  state_nx = ST_CP_RD;
            OP_FILL:  state_nx = ST_FILL;
            default:  state_nx = ST_IDLE;
          endcase
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_RD:    state_nx = ST_RSP;
      ST_WR:    state_nx = DONE_STATE;
      ST_FILL: begin
        step_s = 1'b1;
        if (last_s) begin
          state_nx = DONE_STATE;
        end else begin
          state_nx = ST_FILL;
        end
      end
      ST_CP_RD: state_nx = ST_CP_WR;
      ST_CP_WR: begin
        step_s = 1'b1;
        if (last_s) begin
          state_nx = DONE_STATE;
        end else begin
          state_nx = ST_CP_RD;
        end
      end
      ST_RSP: begin
        if (rsp_ready) begin
          state_nx = ST_IDLE;
        end else begin
          state_nx = ST_RSP;
        end
      end
      default:  state_nx = ST_IDLE;
    endcase
  end

`ifdef RFC_DONE_RSP_EN
  assign count_s = {1'b0, len_r} + {{addr{1'b0}}, 1'b1};
`endif

  // Command latches, copy buffer and response data capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_r     <= '0;
      buf_r      <= '0;
      rsp_data_r <= '0;
`ifdef RFC_DONE_RSP_EN
      len_r      <= '0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid) begin
            data_r <= cmd_data;
`ifdef RFC_DONE_RSP_EN
            len_r  <= cmd_len;
`endif
          end else begin
            data_r <= data_r;
          end
        end
        ST_RD:    rsp_data_r <= rf_data_out;
        ST_CP_RD: buf_r      <= rf_data_out;
`ifdef RFC_DONE_RSP_EN
        ST_WR:    rsp_data_r <= {{(size-1){1'b0}}, 1'b1};
        ST_FILL, ST_CP_WR: begin
          if (last_s) begin
            rsp_data_r <= size'(count_s);
          end else begin
            rsp_data_r <= rsp_data_r;
          end
        end
`endif
        default:  rsp_data_r <= rsp_data_r;
      endcase
    end
  end

  // Output decode from registered state, pointers and latches only.
  always_comb begin
    cmd_ready     = 1'b0;
    rsp_valid     = 1'b0;
    rf_write_en   = is_write_state(state_r);
    rf_write_addr = '0;
    rf_data_in    = '0;
    rf_read_addr  = '0;
    case (state_r)
      ST_IDLE:  cmd_ready = 1'b1;
      ST_RD:    rf_read_addr = cur_src_s;
      ST_WR, ST_FILL: begin
        rf_write_addr = cur_dst_s;
        rf_data_in    = data_r;
      end
      ST_CP_RD: rf_read_addr = cur_src_s;
      ST_CP_WR: begin
        rf_write_addr = cur_dst_s;
        rf_data_in    = buf_r;
      end
      ST_RSP:   rsp_valid = 1'b1;
      default:  cmd_ready = 1'b0;
    endcase
  end

  assign rsp_data = rsp_data_r;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Directed, scoreboarded bench for regfile_access_ctrl with a behavioural
// 16x16 register file attached. Honours RFC_DONE_RSP_EN when defined.
module tb_regfile_access_ctrl;
  import regfile_access_ctrl_pkg::*;

`ifdef RFC_DONE_RSP_EN
  localparam int DX = 1;
`else
  localparam int DX = 0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [3:0]  cmd_src, cmd_dst, cmd_len;
  logic [15:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic [3:0]  rf_write_addr, rf_read_addr;
  logic        rf_write_en;
  logic [15:0] rf_data_in, rf_data_out;

  logic [15:0] mem [16] = '{default: 16'h0000};
  logic [15:0] exp_mem [16] = '{default: 16'h0000};

  typedef struct packed {
    logic [3:0]  a;
    logic [15:0] d;
  } wr_t;
  wr_t         wq[$];
  logic [15:0] rq[$];
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  regfile_access_ctrl dut (
    .clk (clk), .reset_n (reset_n),
    .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_op (cmd_op),
    .cmd_src (cmd_src), .cmd_dst (cmd_dst), .cmd_len (cmd_len), .cmd_data (cmd_data),
    .rsp_valid (rsp_valid), .rsp_ready (rsp_ready), .rsp_data (rsp_data),
    .rf_write_addr (rf_write_addr), .rf_write_en (rf_write_en), .rf_data_in (rf_data_in),
    .rf_read_addr (rf_read_addr), .rf_data_out (rf_data_out)
  );

  // Register file: combinational read, clocked write.
  assign rf_data_out = mem[rf_read_addr];
  always @(posedge clk) begin
    if (rf_write_en) mem[rf_write_addr] <= rf_data_in;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every write strobe must match the next expected (addr, data) in order.
  always @(negedge clk) begin
    wr_t e;
    if (reset_n === 1'b1 && rf_write_en === 1'b1) begin
      check("wr_expected", (wq.size() != 0), 1);
      if (wq.size() != 0) begin
        e = wq.pop_front();
        check("wr_addr", rf_write_addr, e.a);
        check("wr_data", rf_data_in, e.d);
      end
    end
  end

  // Every response transfer must match the next expected response.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      check("rsp_expected", (rq.size() != 0), 1);
      if (rq.size() != 0) check("rsp_data", rsp_data, rq.pop_front());
    end
  end

  // Reference model: expected writes/responses; only the first napply writes
  // are committed to the expected memory image.
  task automatic model(input logic [1:0] op, input logic [3:0] src, input logic [3:0] dst,
                       input logic [3:0] len, input logic [15:0] data, input int napply);
    logic [15:0] snap [16];
    wr_t         list[$];
    wr_t         e;
    int          n;
    int          k;
    logic [3:0]  diff;
    bit          desc;
    snap = exp_mem;
    n    = int'(len) + 1;
    diff = dst - src;
    desc = (diff != 4'd0) && (diff <= len);
    case (op)
      2'b00: rq.push_back(exp_mem[src]);
      2'b01: begin
        e.a = dst; e.d = data; list.push_back(e);
      end
      2'b11: begin
        for (int i = 0; i < n; i++) begin
          e.a = 4'(int'(dst) + i); e.d = data; list.push_back(e);
        end
      end
      default: begin
        for (int i = 0; i < n; i++) begin
          k = desc ? (n - 1 - i) : i;
          e.a = 4'(int'(dst) + k);
          e.d = snap[4'(int'(src) + k)];
          list.push_back(e);
        end
      end
    endcase
    for (int i = 0; i < list.size(); i++) begin
      wq.push_back(list[i]);
      if (i < napply) exp_mem[list[i].a] = list[i].d;
    end
`ifdef RFC_DONE_RSP_EN
    if (op != 2'b00) rq.push_back(16'(list.size()));
`endif
  endtask

  task automatic issue(input logic [1:0] op, input logic [3:0] src, input logic [3:0] dst,
                       input logic [3:0] len, input logic [15:0] data, input int napply);
    int n = 0;
    model(op, src, dst, len, data, napply);
    cmd_op = op; cmd_src = src; cmd_dst = dst; cmd_len = len; cmd_data = data;
    cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("cmd_accept", cmd_ready, 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int exp_busy);
    int n = 0;
    bit done = 1'b0;
    while (!done && n < 300) begin
      @(negedge clk);
      if (cmd_ready === 1'b1) done = 1'b1;
      else n++;
    end
    check("idle_reached", done, 1);
    if (exp_busy >= 0) check("busy_cycles", n, exp_busy);
    check("writes_drained", wq.size(), 0);
  endtask

  task automatic rd(input logic [3:0] a);
    issue(2'b00, a, 4'd0, 4'd0, 16'h0000, 1000);
    wait_idle(2);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_src = 4'd0; cmd_dst = 4'd0;
    cmd_len = 4'd0; cmd_data = 16'h0000; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_wr_en", rf_write_en, 0);
    check("rst_wr_addr", rf_write_addr, 0);
    check("rst_rd_addr", rf_read_addr, 0);
    check("rst_data_in", rf_data_in, 0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset during the third FILL cycle: only addresses 3 and 4 written.
    issue(2'b11, 4'd0, 4'd3, 4'd7, 16'h1234, 2);
    @(posedge clk);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 check("midfill_wr_en", rf_write_en, 0);
    check("midfill_pending", wq.size(), 6);
    wq.delete();
    rq.delete();
    @(negedge clk) reset_n = 1'b1;
    #1;
    check("post_rst_ready", cmd_ready, 1);
    check("post_rst_rsp_valid", rsp_valid, 0);
    check("post_rst_wr_en", rf_write_en, 0);
    rd(4'd2); rd(4'd3); rd(4'd4); rd(4'd5);

    // WRITE then READ with response held off for three cycles.
    issue(2'b01, 4'd0, 4'd5, 4'd0, 16'hBEEF, 1000);
    wait_idle(1 + DX);
    rsp_ready = 1'b0;
    issue(2'b00, 4'd5, 4'd0, 4'd0, 16'h0000, 1000);
    @(negedge clk);
    check("rd_lat1_valid", rsp_valid, 0);
    @(negedge clk);
    check("rd_lat2_valid", rsp_valid, 1);
    check("rd_lat2_data", rsp_data, 16'hBEEF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rd_hold_valid", rsp_valid, 1);
      check("rd_hold_data", rsp_data, 16'hBEEF);
      check("rd_hold_busy", cmd_ready, 0);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    wait_idle(-1);

    // FILL wrapping past the top of the file.
    issue(2'b11, 4'd0, 4'd14, 4'd3, 16'h00A5, 1000);
    wait_idle(4 + DX);
    rd(4'd14); rd(4'd15); rd(4'd0); rd(4'd1); rd(4'd2);

    // Preload regs 0..7 = i, then overlapping forward COPY (descending).
    for (int i = 0; i < 8; i++) begin
      issue(2'b01, 4'd0, 4'(i), 4'd0, 16'(i), 1000);
      wait_idle(1 + DX);
    end
    issue(2'b10, 4'd0, 4'd2, 4'd5, 16'h0000, 1000);
    wait_idle(12 + DX);
    for (int i = 0; i < 8; i++) rd(4'(i));

    // Backward-overlap COPY (ascending).
    issue(2'b10, 4'd4, 4'd2, 4'd3, 16'h0000, 1000);
    wait_idle(8 + DX);
    for (int i = 2; i < 6; i++) rd(4'(i));

    // Full-file self copy.
    issue(2'b10, 4'd0, 4'd0, 4'd15, 16'h0000, 1000);
    wait_idle(32 + DX);
    for (int i = 0; i < 16; i += 3) rd(4'(i));

`ifdef RFC_DONE_RSP_EN
    // Full-file FILL completion response held until consumed.
    rsp_ready = 1'b0;
    issue(2'b11, 4'd0, 4'd0, 4'd15, 16'h0007, 1000);
    repeat (20) @(negedge clk);
    check("done_busy", cmd_ready, 0);
    check("done_valid", rsp_valid, 1);
    check("done_count", rsp_data, 16'd16);
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    wait_idle(-1);
    issue(2'b01, 4'd0, 4'd9, 4'd0, 16'h1111, 1000);
    wait_idle(2);
    rd(4'd9);
`endif

    check("rsp_drained", rq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
